bm_block_sched: RTL and testbench

Sequencer for block-minifloat renormalisation. Admits one block of fixed-point lane vectors into an external single-port-per-direction block buffer and accumulates the block-wide magnitude OR-mask. It then computes the shared pre-shift `current_ps` and drives buffer reads so downstream fxp→minifloat lanes convert the block under one shared exponent. Sits between the accumulator output stream and the per-lane converter bank.

---
 rtl/bm_pkg.sv | 27 ++
 rtl/count_leading_zeros.sv | 25 ++
 rtl/bm_block_sched.sv | 193 +++++++++++++++++++
 tb/tb_bm_block_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// Shared types and helpers for the block-minifloat renormalisation sequencer.
//   state_t   : sequencer states
//   PS_W      : width of the signed shared pre-shift
//   EMAX_DEF  : default maximum biased exponent of the target minifloat
//   lane_mag  : two's-complement magnitude of a sign-extended lane
package bm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CALC  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int PS_W     = 8;
   localparam int EMAX_DEF = 3;

   // Lanes are sign-extended to MAG_W before the call so one function serves
   // any lane width below MAG_W; the caller truncates back to its lane width.
   // The most negative lane value maps onto itself after truncation.
   localparam int MAG_W = 64;

   function automatic logic [MAG_W-1:0] lane_mag(input logic [MAG_W-1:0] x);
      return x[MAG_W-1] ? (~x + MAG_W'(1)) : x;
   endfunction

endpackage

// File: rtl/count_leading_zeros.sv
// Leading-zero counter.
//   din : value to scan, MSB first
//   clz : number of zero bits above the most significant one (WIDTH if din==0)
module count_leading_zeros #(
   parameter int WIDTH = 16,
   localparam int CLZ_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CLZ_W-1:0] clz
);

   logic found;

   always_comb begin
      clz   = CLZ_W'(WIDTH);
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && din[i]) begin
            clz   = CLZ_W'(WIDTH - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bm_block_sched.sv
// Block-minifloat renormalisation sequencer. Admits one block of fixed-point
// lane vectors into an external block buffer while OR-ing lane magnitudes into
// a block mask, derives the shared pre-shift from the mask, then reads the
// block back out to the converter bank under that single pre-shift.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_len           beats per block, sampled on the first beat of a block
//   up_vld/up_rdy     input beat handshake, up_dat = NUM_LANE lanes
//   buf_wr_en/addr    buffer write side (buffer stores up_dat)
//   buf_rd_en/addr    buffer read side (data valid the cycle after rd_en)
//   dn_vld/dn_rdy     output beat handshake, dn_last marks the final beat
//   current_ps        signed shared pre-shift, stable from CALC to block end
//   busy              high whenever not IDLE
//
// Build option BM_PERF_CNT_EN adds perf_blk_cnt (completed blocks) and
// perf_stall_cnt (DRAIN back-pressure cycles plus FILL input bubbles).
//
// state | meaning
// IDLE  | waiting for first beat of a block; latches length
// FILL  | accepting remaining beats, accumulating magnitude mask
// CALC  | one cycle: register pre-shift from mask leading zeros
// DRAIN | reading buffer to converters until the last beat is taken
module bm_block_sched
   import bm_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_LANE   = 8,
   parameter int MAX_BLOCK  = 64,
   parameter int EMAX       = EMAX_DEF,
   localparam int ADDR_W    = $clog2(MAX_BLOCK)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [15:0]                    cfg_len,
   input  logic                           up_vld,
   output logic                           up_rdy,
   input  logic [NUM_LANE*DATA_WIDTH-1:0] up_dat,
   output logic                           buf_wr_en,
   output logic [ADDR_W-1:0]              buf_wr_addr,
   output logic                           buf_rd_en,
   output logic [ADDR_W-1:0]              buf_rd_addr,
   output logic                           dn_vld,
   input  logic                           dn_rdy,
   output logic                           dn_last,
   output logic signed [PS_W-1:0]         current_ps,
   output logic                           busy
`ifdef BM_PERF_CNT_EN
   ,
   output logic [31:0]                    perf_blk_cnt,
   output logic [31:0]                    perf_stall_cnt
`endif
);

   // One extra bit so counters and length can hold MAX_BLOCK itself.
   localparam int CNT_W = ADDR_W + 1;
   localparam int CLZ_W = $clog2(DATA_WIDTH + 1);

   state_t state, state_nxt;

   logic [CNT_W-1:0]      len_q, len_in, wr_cnt, rd_cnt;
   logic [DATA_WIDTH-1:0] mask, beat_mag_or;
   logic [CLZ_W-1:0]      mask_clz;
   logic [31:0]           ps_full;
   logic                  accept, last_out;

   assign accept      = up_vld & up_rdy;
   assign last_out    = dn_vld & dn_rdy & dn_last;
   assign buf_wr_en   = accept;
   assign buf_wr_addr = wr_cnt[ADDR_W-1:0];
   assign buf_rd_addr = rd_cnt[ADDR_W-1:0];

   always_comb begin
      if (cfg_len == '0)
         len_in = CNT_W'(1);
      else if (cfg_len > 16'(MAX_BLOCK))
         len_in = CNT_W'(MAX_BLOCK);
      else
         len_in = cfg_len[CNT_W-1:0];
   end

   always_comb begin
      beat_mag_or = '0;
      for (int j = 0; j < NUM_LANE; j++) begin
         beat_mag_or = beat_mag_or | DATA_WIDTH'(lane_mag(
            {{(MAG_W-DATA_WIDTH){up_dat[j*DATA_WIDTH+DATA_WIDTH-1]}},
             up_dat[j*DATA_WIDTH +: DATA_WIDTH]}));
      end
   end

   count_leading_zeros #(.WIDTH(DATA_WIDTH)) u_clz (
      .din (mask),
      .clz (mask_clz)
   );

   // shift - EMAX - 1 with shift = DATA_WIDTH - clz; modular 32-bit math,
   // low PS_W bits give the signed result.
   assign ps_full = 32'(DATA_WIDTH) - 32'(mask_clz) - 32'(EMAX) - 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      up_rdy    = 1'b0;
      buf_rd_en = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            up_rdy = 1'b1;
            if (up_vld)
               state_nxt = (len_in == CNT_W'(1)) ? CALC : FILL;
         end
         FILL: begin
            up_rdy = 1'b1;
            if (up_vld && (wr_cnt == len_q - CNT_W'(1)))
               state_nxt = CALC;
         end
         CALC: state_nxt = DRAIN;
         DRAIN: begin
            buf_rd_en = (rd_cnt < len_q) && (!dn_vld || dn_rdy);
            if (last_out)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q      <= '0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         mask       <= '0;
         current_ps <= '0;
         dn_vld     <= 1'b0;
         dn_last    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  len_q  <= len_in;
                  mask   <= beat_mag_or;
                  wr_cnt <= CNT_W'(1);
               end
            end
            FILL: begin
               if (accept) begin
                  mask   <= mask | beat_mag_or;
                  wr_cnt <= wr_cnt + CNT_W'(1);
               end
            end
            CALC: begin
               current_ps <= ps_full[PS_W-1:0];
               rd_cnt     <= '0;
            end
            DRAIN: begin
               if (buf_rd_en) begin
                  rd_cnt  <= rd_cnt + CNT_W'(1);
                  dn_vld  <= 1'b1;
                  dn_last <= (rd_cnt == len_q - CNT_W'(1));
               end else if (dn_rdy) begin
                  dn_vld  <= 1'b0;
                  dn_last <= 1'b0;
               end
               if (last_out) begin
                  mask   <= '0;
                  rd_cnt <= '0;
                  wr_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BM_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_blk_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (last_out)
            perf_blk_cnt <= perf_blk_cnt + 32'd1;
         if ((state == DRAIN && dn_vld && !dn_rdy) || (state == FILL && !up_vld))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bm_block_sched.sv
// Directed bench for bm_block_sched; models the external block buffer.
module tb_bm_block_sched;

   localparam int DW = 16;
   localparam int NL = 8;
   localparam int BW = DW * NL;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   cfg_len;
   logic          up_vld, up_rdy;
   logic [BW-1:0] up_dat;
   logic          buf_wr_en, buf_rd_en;
   logic [AW-1:0] buf_wr_addr, buf_rd_addr;
   logic          dn_vld, dn_rdy, dn_last, busy;
   logic [7:0]    current_ps;
`ifdef BM_PERF_CNT_EN
   logic [31:0]   perf_blk_cnt, perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   bm_block_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_len     (cfg_len),
      .up_vld      (up_vld),
      .up_rdy      (up_rdy),
      .up_dat      (up_dat),
      .buf_wr_en   (buf_wr_en),
      .buf_wr_addr (buf_wr_addr),
      .buf_rd_en   (buf_rd_en),
      .buf_rd_addr (buf_rd_addr),
      .dn_vld      (dn_vld),
      .dn_rdy      (dn_rdy),
      .dn_last     (dn_last),
      .current_ps  (current_ps),
      .busy        (busy)
`ifdef BM_PERF_CNT_EN
      ,
      .perf_blk_cnt   (perf_blk_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   // External buffer: write on strobe, read data registered and held.
   logic [BW-1:0] mem [0:63];
   logic [BW-1:0] rd_data;
   int            wr_log[$];

   always @(posedge clk) begin
      if (buf_wr_en) begin
         mem[buf_wr_addr] <= up_dat;
         wr_log.push_back(int'(buf_wr_addr));
      end
      if (buf_rd_en) rd_data <= mem[buf_rd_addr];
   end

   int nvec = 0;
   int nerr = 0;

   logic [BW-1:0] in_beats[$];
   logic [BW-1:0] out_dat[$];
   logic          out_last[$];
   int            out_addr[$];
   int            first_vld, stall_rd_en, stall_chg, stall_vld_low;
   logic          calc_up_rdy, calc_busy;
   bit            to_flag;

   function automatic logic [BW-1:0] rep(input logic [15:0] v);
      return {NL{v}};
   endfunction

   function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int lane,
                                         input logic [15:0] v);
      b[lane*DW +: DW] = v;
      return b;
   endfunction

   task automatic push(input int cfg, input int cfg_after, input int gap);
      int g;
      for (int i = 0; i < in_beats.size(); i++) begin
         if (i > 0) repeat (gap) begin @(negedge clk); up_vld = 1'b0; end
         @(negedge clk);
         cfg_len = 16'((i == 0) ? cfg : cfg_after);
         up_vld  = 1'b1;
         up_dat  = in_beats[i];
         #1;
         g = 0;
         while (!up_rdy && g < 50) begin @(negedge clk); #1; g++; end
         if (g >= 50) to_flag = 1'b1;
      end
   endtask

   task automatic drain(input int stall_after, input int stall_len);
      int n, consumed, left;
      logic [BW-1:0] held;
      bit done;
      n = 0; consumed = 0; left = stall_len; done = 1'b0; held = '0;
      out_dat.delete(); out_last.delete(); out_addr.delete();
      first_vld = -1; stall_rd_en = 0; stall_chg = 0; stall_vld_low = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
         up_vld = 1'b0;
         if (consumed == stall_after && left > 0) begin dn_rdy = 1'b0; left--; end
         else dn_rdy = 1'b1;
         #1;
         if (n == 1) begin calc_up_rdy = up_rdy; calc_busy = busy; end
         if (dn_vld && first_vld < 0) first_vld = n;
         if (buf_rd_en) out_addr.push_back(int'(buf_rd_addr));
         if (!dn_rdy) begin
            if (left == stall_len - 1) held = rd_data;
            if (buf_rd_en) stall_rd_en++;
            if (!dn_vld) stall_vld_low++;
            if (rd_data !== held) stall_chg++;
         end
         if (dn_vld && dn_rdy) begin
            out_dat.push_back(rd_data);
            out_last.push_back(dn_last);
            consumed++;
            if (dn_last) done = 1'b1;
         end
      end
      if (!done) to_flag = 1'b1;
      dn_rdy = 1'b1;
   endtask

   // Common per-block checks: completion, pre-shift, beat count, data order,
   // dn_last exactly on the final beat, and rd address sequence 0..n-1.
   task automatic test_block_result(input string nm, input logic [7:0] exp_ps);
      int bad, nlast, nexp;
      nexp = in_beats.size();
      nvec++;
      if (to_flag !== 1'b0) begin nerr++; $display("FAIL %s_timeout: got %0d want 0", nm, to_flag); end
      nvec++;
      if (current_ps !== exp_ps) begin nerr++; $display("FAIL %s_ps: got %0h want %0h", nm, current_ps, exp_ps); end
      nvec++;
      if (out_dat.size() != nexp) begin nerr++; $display("FAIL %s_count: got %0d want %0d", nm, out_dat.size(), nexp); end
      bad = 0; nlast = 0;
      foreach (out_dat[i]) begin
         if (i < nexp && out_dat[i] !== in_beats[i]) bad++;
         nlast += int'(out_last[i]);
      end
      nvec++;
      if (bad != 0) begin nerr++; $display("FAIL %s_data: got %0d bad beats want 0", nm, bad); end
      nvec++;
      if (nlast != 1 || out_last.size() != nexp || out_last[nexp-1] !== 1'b1) begin
         nerr++; $display("FAIL %s_last: got %0d last flags want 1 on beat %0d", nm, nlast, nexp);
      end
      bad = 0;
      foreach (out_addr[i]) if (out_addr[i] != i) bad++;
      nvec++;
      if (bad != 0 || out_addr.size() != nexp) begin
         nerr++; $display("FAIL %s_rd_addr: got %0d reads (%0d out of order) want %0d", nm, out_addr.size(), bad, nexp);
      end
   endtask

   task automatic test_reset();
      #12;
      nvec++;
      if (busy !== 1'b0 || dn_vld !== 1'b0 || dn_last !== 1'b0 || buf_rd_en !== 1'b0) begin
         nerr++; $display("FAIL reset_ctl: got busy=%b vld=%b last=%b rd=%b want 0000", busy, dn_vld, dn_last, buf_rd_en);
      end
      nvec++;
      if (current_ps !== 8'h00) begin nerr++; $display("FAIL reset_ps: got %0h want 0", current_ps); end
      nvec++;
      if (buf_wr_addr !== 6'd0) begin nerr++; $display("FAIL reset_wr_addr: got %0d want 0", buf_wr_addr); end
      @(negedge clk); rst_n = 1'b1; #1;
      nvec++;
      if (up_rdy !== 1'b1) begin nerr++; $display("FAIL reset_up_rdy: got %b want 1", up_rdy); end
   endtask

   task automatic test_l2();
      to_flag = 1'b0; wr_log.delete(); in_beats.delete();
      in_beats.push_back(put(rep(16'h0012), 3, 16'h0100));
      in_beats.push_back(put(rep(16'h00FF), 5, 16'hFFF0));
      push(2, 2, 0);
      drain(99, 0);
      test_block_result("l2", 8'h05);
      nvec++;
      if (first_vld != 3) begin nerr++; $display("FAIL l2_latency: got %0d want 3", first_vld); end
      nvec++;
      if (wr_log.size() != 2 || wr_log[0] != 0 || wr_log[1] != 1) begin
         nerr++; $display("FAIL l2_wr_addr: got %0d writes want 2 at 0,1", wr_log.size());
      end
   endtask

   task automatic test_l4_neg();
      to_flag = 1'b0; in_beats.delete();
      in_beats.push_back(put(rep(16'h0001), 2, 16'hFE00));
      in_beats.push_back(rep(16'hFFFF));
      in_beats.push_back(rep(16'h0003));
      in_beats.push_back(put(rep(16'h0000), 7, 16'h01FF));
      push(4, 4, 1);
      drain(99, 0);
      test_block_result("l4neg", 8'h06);
   endtask

   task automatic test_zero_l3();
      to_flag = 1'b0; in_beats.delete();
      repeat (3) in_beats.push_back(rep(16'h0000));
      push(3, 3, 0);
      drain(99, 0);
      test_block_result("zero", 8'hFC);
   endtask

   task automatic test_len1();
      to_flag = 1'b0; in_beats.delete();
      in_beats.push_back(put(rep(16'h0000), 0, 16'h8000));
      push(1, 1, 0);
      drain(99, 0);
      test_block_result("len1", 8'h0C);
      nvec++;
      if (calc_up_rdy !== 1'b0 || calc_busy !== 1'b1) begin
         nerr++; $display("FAIL len1_calc: got up_rdy=%b busy=%b want 0 1", calc_up_rdy, calc_busy);
      end
      nvec++;
      if (first_vld != 3) begin nerr++; $display("FAIL len1_latency: got %0d want 3", first_vld); end
   endtask

   task automatic test_len0();
      to_flag = 1'b0; in_beats.delete();
      in_beats.push_back(rep(16'h0001));
      push(0, 0, 0);
      drain(99, 0);
      test_block_result("len0", 8'hFD);
   endtask

   task automatic test_len100();
      to_flag = 1'b0; in_beats.delete();
      for (int i = 0; i < 64; i++) in_beats.push_back(rep(16'(i)));
      push(100, 2, 0);
      drain(99, 0);
      test_block_result("len100", 8'h02);
   endtask

   task automatic test_backpressure();
      to_flag = 1'b0; in_beats.delete();
      for (int i = 0; i < 4; i++) in_beats.push_back(rep(16'h0010 + 16'(i)));
      push(4, 4, 0);
      drain(1, 3);
      test_block_result("bp", 8'h01);
      nvec++;
      if (stall_rd_en != 0) begin nerr++; $display("FAIL bp_rd_en: got %0d reads in stall want 0", stall_rd_en); end
      nvec++;
      if (stall_vld_low != 0) begin nerr++; $display("FAIL bp_vld_held: got %0d low cycles want 0", stall_vld_low); end
      nvec++;
      if (stall_chg != 0) begin nerr++; $display("FAIL bp_data_stable: got %0d changes want 0", stall_chg); end
   endtask

   task automatic test_reset_mid();
      int nrd, g;
      to_flag = 1'b0; in_beats.delete();
      repeat (4) in_beats.push_back(rep(16'h4000));
      push(4, 4, 0);
      nrd = 0; g = 0;
      while (nrd < 2 && g < 50) begin
         @(negedge clk); up_vld = 1'b0; #1;
         if (buf_rd_en) nrd++;
         g++;
      end
      nvec++;
      if (nrd != 2) begin nerr++; $display("FAIL rstmid_reads: got %0d want 2", nrd); end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b0; #1;
      nvec++;
      if (dn_vld !== 1'b0 || up_rdy !== 1'b1 || busy !== 1'b0 || buf_rd_en !== 1'b0) begin
         nerr++; $display("FAIL rstmid_state: got vld=%b up_rdy=%b busy=%b rd=%b want 0 1 0 0", dn_vld, up_rdy, busy, buf_rd_en);
      end
      @(negedge clk); rst_n = 1'b1;
      in_beats.delete();
      in_beats.push_back(rep(16'h0003));
      in_beats.push_back(rep(16'h0002));
      push(2, 2, 0);
      drain(99, 0);
      test_block_result("rstmid_new", 8'hFE);
   endtask

`ifdef BM_PERF_CNT_EN
   task automatic test_perf();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      to_flag = 1'b0; in_beats.delete();
      in_beats.push_back(rep(16'h0007));
      in_beats.push_back(rep(16'h0005));
      push(2, 2, 0); drain(99, 0);
      push(2, 2, 0); drain(1, 2);
      push(2, 2, 0); drain(99, 0);
      @(negedge clk); #1;
      nvec++;
      if (perf_blk_cnt !== 32'd3) begin nerr++; $display("FAIL perf_blk: got %0d want 3", perf_blk_cnt); end
      nvec++;
      if (perf_stall_cnt !== 32'd2) begin nerr++; $display("FAIL perf_stall: got %0d want 2", perf_stall_cnt); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; up_vld = 1'b0; up_dat = '0; dn_rdy = 1'b1; cfg_len = '0;
      test_reset();
      test_l2();
      test_l4_neg();
      test_zero_l3();
      test_len1();
      test_len0();
      test_len100();
      test_backpressure();
      test_reset_mid();
`ifdef BM_PERF_CNT_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
